ser8: RTL and testbench

Parallel-to-serial converter that accepts one WIDTH-bit word per handshake and emits it one bit per accepted beat, LSB first by default, with first/last framing. It is the transmit end of the datapath's 8-bit register stage: it unloads a stored parallel operand into the bit-serial arithmetic units (serial adders and multipliers), which consume operands LSB first.

---
 rtl/ser8.sv | 132 +++++++++++++
 tb/tb_ser8.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ser8.sv
// ser8: parallel-to-serial converter feeding the bit-serial arithmetic units.
// One WIDTH-bit word per load handshake, one bit per output beat, with first/last framing.
module ser8 #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             first,
    output logic             last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] sh_r;
    logic [WIDTH-1:0] sh_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    logic             first_r;
    logic             first_s;
    logic             last_r;
    logic             last_s;
    logic             beat_s;
    logic             load_s;
    logic             ready_s;

    // Handshake decode; a word may load on the same edge that drains the final bit.
    always_comb begin
        ready_s = 1'b0;
        if (state_r == IDLE) begin
            ready_s = 1'b1;
        end else begin
            ready_s = last_r && sout_ready;
        end
        beat_s = (state_r == SHIFT) && sout_ready;
        load_s = load_valid && ready_s;
    end

    // Next-state, shift and counter logic; framing flags are precomputed for the next cycle.
    always_comb begin
        state_s = state_r;
        sh_s    = sh_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (load_s) begin
                    state_s = SHIFT;
                    sh_s    = in;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (load_s) begin
                    state_s = SHIFT;
                    sh_s    = in;
                    cnt_s   = CNT_ZERO;
                end else if (beat_s) begin
                    if (LSB_FIRST) begin
                        sh_s = {1'b0, sh_r[WIDTH-1:1]};
                    end else begin
                        sh_s = {sh_r[WIDTH-2:0], 1'b0};
                    end
                    // The counter parks at zero instead of wrapping past the last bit.
                    if (last_r) begin
                        state_s = IDLE;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
                sh_s    = {WIDTH{1'b0}};
                cnt_s   = CNT_ZERO;
            end
        endcase
        first_s = 1'b0;
        last_s  = 1'b0;
        if (state_s == SHIFT) begin
            first_s = (cnt_s == CNT_ZERO);
            last_s  = (cnt_s == CNT_LAST);
        end else begin
            first_s = 1'b0;
            last_s  = 1'b0;
        end
    end

    // State, datapath and framing-flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            sh_r    <= {WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
            first_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            sh_r    <= sh_s;
            cnt_r   <= cnt_s;
            first_r <= first_s;
            last_r  <= last_s;
        end
    end

    assign sout       = LSB_FIRST ? sh_r[0] : sh_r[WIDTH-1];
    assign sout_valid = (state_r == SHIFT);
    assign first      = first_r;
    assign last       = last_r;
    assign load_ready = ready_s;

endmodule

// File: tb/tb_ser8.sv
// Self-checking bench for ser8: four instances (8/LSB, 8/MSB, 2/LSB, 32/MSB) checked each cycle
// against a word/beat-index model, plus directed sequences from the test plan.
module tb_ser8;

    logic        clock;
    logic        reset_n;
    logic [31:0] din [4];
    logic [3:0]  lv;
    logic [3:0]  sr;
    logic [3:0]  so;
    logic [3:0]  sv;
    logic [3:0]  fi;
    logic [3:0]  la;
    logic [3:0]  lr;

    int n_checks = 0;
    int n_fail   = 0;

    int W  [4] = '{8, 8, 2, 32};
    bit LF [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    bit          m_busy   [4];
    logic [31:0] m_word   [4];
    int          m_k      [4];
    bit          m_loaded [4];
    logic [31:0] m_asm    [4];
    int          m_nfirst [4];
    int          m_nlast  [4];
    int          m_words  [4];

    ser8 #(.WIDTH(8), .LSB_FIRST(1'b1)) u0 (
        .clock(clock), .reset_n(reset_n), .in(din[0][7:0]), .load_valid(lv[0]),
        .load_ready(lr[0]), .sout(so[0]), .sout_valid(sv[0]), .sout_ready(sr[0]),
        .first(fi[0]), .last(la[0]));
    ser8 #(.WIDTH(8), .LSB_FIRST(1'b0)) u1 (
        .clock(clock), .reset_n(reset_n), .in(din[1][7:0]), .load_valid(lv[1]),
        .load_ready(lr[1]), .sout(so[1]), .sout_valid(sv[1]), .sout_ready(sr[1]),
        .first(fi[1]), .last(la[1]));
    ser8 #(.WIDTH(2), .LSB_FIRST(1'b1)) u2 (
        .clock(clock), .reset_n(reset_n), .in(din[2][1:0]), .load_valid(lv[2]),
        .load_ready(lr[2]), .sout(so[2]), .sout_valid(sv[2]), .sout_ready(sr[2]),
        .first(fi[2]), .last(la[2]));
    ser8 #(.WIDTH(32), .LSB_FIRST(1'b0)) u3 (
        .clock(clock), .reset_n(reset_n), .in(din[3]), .load_valid(lv[3]),
        .load_ready(lr[3]), .sout(so[3]), .sout_valid(sv[3]), .sout_ready(sr[3]),
        .first(fi[3]), .last(la[3]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wmask(input int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

    task automatic model_clear();
        for (int id = 0; id < 4; id++) begin
            m_busy[id]   = 1'b0;
            m_k[id]      = 0;
            m_loaded[id] = 1'b0;
        end
    endtask

    // Called at a negedge with inputs already driven; checks this cycle and advances one edge.
    task automatic step();
        bit beat [4];
        bit ld   [4];
        #1;
        for (int id = 0; id < 4; id++) begin
            bit e_last;
            bit e_ready;
            int pos;
            e_last  = m_busy[id] && (m_k[id] == W[id] - 1);
            e_ready = !m_busy[id] || (e_last && sr[id]);
            chk($sformatf("valid%0d", id), 32'(sv[id]), 32'(m_busy[id]));
            chk($sformatf("first%0d", id), 32'(fi[id]), 32'(m_busy[id] && m_k[id] == 0));
            chk($sformatf("last%0d", id), 32'(la[id]), 32'(e_last));
            chk($sformatf("ready%0d", id), 32'(lr[id]), 32'(e_ready));
            pos = LF[id] ? m_k[id] : (W[id] - 1 - m_k[id]);
            if (m_busy[id]) begin
                chk($sformatf("sout%0d", id), 32'(so[id]), 32'(m_word[id][pos]));
            end
            beat[id] = m_busy[id] && sr[id];
            ld[id]   = lv[id] && e_ready;
            if (beat[id]) begin
                m_asm[id][pos] = so[id];
                if (fi[id]) m_nfirst[id]++;
                if (la[id]) m_nlast[id]++;
            end
        end
        @(posedge clock);
        for (int id = 0; id < 4; id++) begin
            if (beat[id]) begin
                m_k[id]++;
                if (m_k[id] == W[id]) begin
                    chk($sformatf("word%0d", id), m_asm[id], m_word[id]);
                    chk($sformatf("nfirst%0d", id), m_nfirst[id], 1);
                    chk($sformatf("nlast%0d", id), m_nlast[id], 1);
                    m_words[id]++;
                    m_busy[id] = 1'b0;
                end
            end
            m_loaded[id] = ld[id];
            if (ld[id]) begin
                m_busy[id]   = 1'b1;
                m_word[id]   = din[id] & wmask(W[id]);
                m_k[id]      = 0;
                m_asm[id]    = 32'h0;
                m_nfirst[id] = 0;
                m_nlast[id]  = 0;
            end
        end
        @(negedge clock);
    endtask

    task automatic check_reset_outputs();
        for (int id = 0; id < 4; id++) begin
            chk($sformatf("rst_sout%0d", id), 32'(so[id]), 32'h0);
            chk($sformatf("rst_valid%0d", id), 32'(sv[id]), 32'h0);
            chk($sformatf("rst_first%0d", id), 32'(fi[id]), 32'h0);
            chk($sformatf("rst_last%0d", id), 32'(la[id]), 32'h0);
            chk($sformatf("rst_ready%0d", id), 32'(lr[id]), 32'h1);
        end
    endtask

    initial begin
        logic [7:0]  w_a;
        logic [7:0]  w_b;
        logic [15:0] pair;
        int          n;

        reset_n = 1'b0;
        lv = 4'h0;
        sr = 4'h0;
        for (int id = 0; id < 4; id++) begin
            din[id] = 32'h0;
            m_words[id] = 0;
        end
        model_clear();
        #1;
        check_reset_outputs();
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // Basic serialization of 8'hA5, LSB first.
        w_a = 8'hA5;
        din[0] = 32'hA5; lv[0] = 1'b1; sr[0] = 1'b1;
        step();
        lv[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("a5_bit", 32'(so[0]), 32'(w_a[i]));
            chk("a5_first", 32'(fi[0]), 32'(i == 0));
            chk("a5_last", 32'(la[0]), 32'(i == 7));
            step();
        end
        chk("a5_idle", 32'(sv[0]), 32'h0);
        step();

        // MSB first, 8'h81 then 8'h3C back to back.
        pair = 16'h813C;
        din[1] = 32'h81; lv[1] = 1'b1; sr[1] = 1'b1;
        chk("msb_ready0", 32'(lr[1]), 32'h1);
        step();
        din[1] = 32'h3C;
        for (int i = 0; i < 16; i++) begin
            chk("msb_bit", 32'(so[1]), 32'(pair[15 - i]));
            chk("msb_valid", 32'(sv[1]), 32'h1);
            if (i == 7) begin
                #1;
                chk("msb_ready8", 32'(lr[1]), 32'h1);
            end
            step();
            if (i == 7) lv[1] = 1'b0;
        end
        step();

        // Backpressure on 8'hF0: three stall cycles starting at beat 2.
        din[0] = 32'hF0; lv[0] = 1'b1; sr[0] = 1'b1;
        step();
        lv[0] = 1'b0;
        n = 0;
        while (sv[0] && n < 20) begin
            sr[0] = (n >= 2 && n <= 4) ? 1'b0 : 1'b1;
            step();
            n++;
        end
        chk("f0_cycles", n, 11);
        sr[0] = 1'b1;
        step();

        // Load request held mid-word must wait for the final beat.
        din[0] = 32'hC3; lv[0] = 1'b1;
        step();
        lv[0] = 1'b0;
        step(); step(); step();
        din[0] = 32'h55; lv[0] = 1'b1;
        n = 0;
        while (!m_loaded[0] && n < 20) begin
            step();
            n++;
        end
        chk("held_load_wait", n, 5);
        lv[0] = 1'b0;
        w_b = 8'h55;
        chk("h55_first", 32'(fi[0]), 32'h1);
        chk("h55_bit0", 32'(so[0]), 32'(w_b[0]));
        for (int i = 0; i < 9; i++) step();

        // Reset in the middle of 8'hFF, then 8'h01.
        din[0] = 32'hFF; lv[0] = 1'b1;
        step();
        lv[0] = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("ff_beat4_valid", 32'(sv[0]), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        model_clear();
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_reset_outputs();
        din[0] = 32'h01; lv[0] = 1'b1;
        step();
        lv[0] = 1'b0;
        w_a = 8'h01;
        for (int i = 0; i < 8; i++) begin
            chk("h01_bit", 32'(so[0]), 32'(w_a[i]));
            chk("h01_first", 32'(fi[0]), 32'(i == 0));
            step();
        end
        step();

        // Random sweep on the WIDTH=2 and WIDTH=32 instances.
        for (int c = 0; c < 600; c++) begin
            for (int id = 2; id < 4; id++) begin
                if (!lv[id] || m_loaded[id]) begin
                    lv[id]  = ($urandom_range(3, 0) != 0);
                    din[id] = $urandom() & wmask(W[id]);
                end
                sr[id] = ($urandom_range(3, 0) != 0);
            end
            step();
        end
        lv[2] = 1'b0; lv[3] = 1'b0;
        sr[2] = 1'b1; sr[3] = 1'b1;
        n = 0;
        while ((sv[2] || sv[3]) && n < 100) begin
            step();
            n++;
        end
        chk("sweep_drained", 32'(sv[3:2]), 32'h0);
        chk("sweep_w2_words", 32'(m_words[2] > 20), 32'h1);
        chk("sweep_w32_words", 32'(m_words[3] > 5), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
